// File: rtl/music_pkg.sv
// Shared types and note tables for the music sequencer.
package music_pkg;

  // 4-bit note code: 0 = silence, 1..14 = c..hb, 15 unused (decodes to silence)
  typedef logic [3:0] note_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] F_C  = 32'd262;
  localparam logic [31:0] F_D  = 32'd294;
  localparam logic [31:0] F_E  = 32'd330;
  localparam logic [31:0] F_F  = 32'd349;
  localparam logic [31:0] F_G  = 32'd392;
  localparam logic [31:0] F_A  = 32'd440;
  localparam logic [31:0] F_B  = 32'd494;
  localparam logic [31:0] F_HC = 32'd524;
  localparam logic [31:0] F_HD = 32'd588;
  localparam logic [31:0] F_HE = 32'd660;
  localparam logic [31:0] F_HF = 32'd698;
  localparam logic [31:0] F_HG = 32'd784;
  localparam logic [31:0] F_HA = 32'd880;
  localparam logic [31:0] F_HB = 32'd988;
  localparam logic [31:0] SIL  = 32'd50000000;

  // Beats at or beyond this index are silent in the default song
  localparam logic [11:0] SONG_NOTE_BEATS = 12'd56;

  // Note code to frequency; anything outside 1..14 is silence
  function automatic logic [31:0] note_freq(input note_t n);
    logic [31:0] f;
    case (n)
      4'd1:    f = F_C;
      4'd2:    f = F_D;
      4'd3:    f = F_E;
      4'd4:    f = F_F;
      4'd5:    f = F_G;
      4'd6:    f = F_A;
      4'd7:    f = F_B;
      4'd8:    f = F_HC;
      4'd9:    f = F_HD;
      4'd10:   f = F_HE;
      4'd11:   f = F_HF;
      4'd12:   f = F_HG;
      4'd13:   f = F_HA;
      4'd14:   f = F_HB;
      default: f = SIL;
    endcase
    return f;
  endfunction

  // Octave shift: exactly one of up/dn moves the pitch; silence is never touched
  function automatic logic [31:0] oct_shift(input logic [31:0] f,
                                            input logic up, input logic dn);
    logic [31:0] r;
    r = f;
    if (f != SIL && (up ^ dn))
      r = up ? (f << 1) : (f >> 1);
    return r;
  endfunction

endpackage

// File: rtl/music_tempo_gen.sv
// Beat timebase: counts clk cycles within a beat and flags the terminal tick.
module music_tempo_gen
  import music_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 25000000
) (
  input  logic clk,
  input  logic rst,          // async, active-low
  input  logic clr_i,        // restart the beat from tick 0
  input  logic en_i,         // advance one tick this cycle
  output logic beat_tick_o   // one-cycle pulse on the last tick of a beat
);

  localparam int unsigned TW = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);

  logic [TW-1:0] tick_q, tick_d;

  // clear wins over counting so a restart never also emits a beat
  assign beat_tick_o = en_i && !clr_i && (tick_q == TICK_LAST);

  // next tick: clear, wrap at terminal tick, or hold when not enabled
  always_comb begin
    tick_d = tick_q;
    if (clr_i)
      tick_d = '0;
    else if (en_i)
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
  end

  // tick counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_q <= '0;
    else      tick_q <= tick_d;
  end

endmodule

// File: rtl/music_sequencer.sv
// Multi-channel song player: playback FSM, song table and registered tones.
module music_sequencer
  import music_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned SONG_LEN       = 64,
  parameter int unsigned TICKS_PER_BEAT = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,       // async, active-low
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
  input  logic                  oct_up,
  input  logic                  oct_dn,
  input  logic [NUM_CH-1:0]     mute,
  output logic [32*NUM_CH-1:0]  tone,
  output logic [11:0]           beat_num,
  output logic                  playing,
  output logic                  done
);

  localparam logic [11:0] BEAT_LAST = 12'(SONG_LEN - 1);

  state_t      state_q;
  logic [11:0] beat_q;
  logic        playing_q, done_q;
  logic        beat_tick;
  logic        tick_en, tick_clr;
  note_t       cur_note;
  logic [31:0] cur_freq;

  // Default song: every channel plays (beat>>2)+1 for the first 56 beats
  function automatic note_t song_note(input logic [11:0] beat);
    note_t n;
    n = '0;
    if (beat < SONG_NOTE_BEATS)
      n = note_t'(beat[5:2] + 4'd1);
    return n;
  endfunction

  // tick only advances in PLAY on cycles with no command pending;
  // the cycle that enters or leaves PAUSE does not consume a tick
  assign tick_en  = (state_q == S_PLAY) && !pause;
  assign tick_clr = stop || start;

  music_tempo_gen #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT)
  ) u_tempo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (tick_clr),
    .en_i        (tick_en),
    .beat_tick_o (beat_tick)
  );

  // Playback FSM with stop > start > pause priority and registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q   <= S_IDLE;
        beat_q    <= '0;
        playing_q <= 1'b0;
      end else if (start) begin
        state_q   <= S_PLAY;
        beat_q    <= '0;
        playing_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_PLAY: begin
            if (pause) begin
              state_q   <= S_PAUSE;
              playing_q <= 1'b0;
            end else if (beat_tick) begin
              if (beat_q == BEAT_LAST) begin
                beat_q <= '0;
                if (!loop_en) begin
                  // one-shot end: park at beat 0 and pulse done for one cycle
                  state_q   <= S_DONE;
                  playing_q <= 1'b0;
                  done_q    <= 1'b1;
                end
              end else begin
                beat_q <= beat_q + 12'd1;
              end
            end
          end
          S_PAUSE: begin
            if (!pause) begin
              state_q   <= S_PLAY;
              playing_q <= 1'b1;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cur_note = song_note(beat_q);
  assign cur_freq = oct_shift(note_freq(cur_note), oct_up, oct_dn);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [31:0] tone_q;

    // per-channel tone, one cycle behind beat/state, mute and octave inputs
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        tone_q <= SIL;
      else if (state_q != S_PLAY || mute[k])
        tone_q <= SIL;
      else
        tone_q <= cur_freq;
    end

    assign tone[32*k +: 32] = tone_q;
  end

  assign beat_num = beat_q;
  assign playing  = playing_q;
  assign done     = done_q;

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of tone channels.
REQ-002 SHALL have parameter SONG_LEN, default 64, beats per song (2..4096).
REQ-003 SHALL have parameter TICKS_PER_BEAT, default 25000000, clk cycles per beat (>=2).
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  level; begin playback from beat 0.
REQ-007 SHALL have port stop  in  1  level; abort playback.
REQ-008 SHALL have port pause  in  1  level; hold position while high.
REQ-009 SHALL have port loop_en  in  1  1 = wrap at song end, 0 = one-shot.
REQ-010 SHALL have port oct_up  in  1  double all non-silent frequencies.
REQ-011 SHALL have port oct_dn  in  1  halve all non-silent frequencies.
REQ-012 SHALL have port mute  in  NUM_CH  per-channel force-silence mask.
REQ-013 SHALL have port tone  out  32*NUM_CH  channel k frequency in bits [32k+31:32k], registered.
REQ-014 SHALL have port beat_num  out  12  current beat index, registered.
REQ-015 SHALL have port playing  out  1  high in PLAY state only.
REQ-016 SHALL have port done  out  1  one-cycle pulse at one-shot song end.

Function
REQ-017 SHALL implement FSM states IDLE, PLAY, PAUSE, DONE.
REQ-018 Command priority SHALL be stop > start > pause, evaluated every cycle.
REQ-019 IDLE: start -> PLAY with beat_num=0, tick=0; otherwise stay.
REQ-020 PLAY: tick counts 0..TICKS_PER_BEAT-1; at terminal tick beat_num increments and tick clears.
REQ-021 PLAY at terminal tick of beat SONG_LEN-1: loop_en=1 -> beat_num=0, stay PLAY; loop_en=0 -> DONE.
REQ-022 PLAY: pause=1 (no stop/start) -> PAUSE; tick and beat_num frozen.
REQ-023 PAUSE: pause=0 -> PLAY, resuming at the frozen tick and beat_num.
REQ-024 start in PLAY or PAUSE SHALL restart: beat_num=0, tick=0, state PLAY.
REQ-025 stop in any state SHALL go to IDLE with beat_num=0, tick=0.
REQ-026 DONE SHALL last exactly one cycle, assert done, then go to IDLE (start in DONE -> PLAY instead).
REQ-027 Note per (channel, beat) SHALL be a 4-bit code: 0 = silence, 1..14 = c..hb; beats >= 56 and codes >14 decode to silence.
REQ-028 Frequencies SHALL be c 262, d 294, e 330, f 349, g 392, a 440, b 494, hc 524, hd 588, he 660, hf 698, hg 784, ha 880, hb 988; silence = 50000000.
REQ-029 Default song: every channel plays code ((beat>>2)+1) for beats 0..55, silence after.
REQ-030 Octave: oct_up xor oct_dn =1 SHALL shift frequency left/right by 1; both or neither -> unshifted; silence never shifted.
REQ-031 tone[k] SHALL be silence when state != PLAY or mute[k]=1.
REQ-032 tone SHALL reflect beat_num with one-cycle latency (registered after beat_num update).
REQ-033 oct_up, oct_dn, mute changes SHALL take effect on tone one cycle later, mid-beat allowed.

Reset
REQ-034 rst low SHALL force state IDLE, tick=0, beat_num=0, tone all silence, playing=0, done=0, asynchronously.
REQ-035 rst deassertion mid-song SHALL leave the block in IDLE; playback requires a new start.

Structure
REQ-036 Package music_pkg SHALL hold the note-code typedef, the 14 frequency constants, SIL, and the note-to-frequency function.
REQ-037 One sub-module music_tempo_gen SHALL hold the tick counter and emit a one-cycle beat_tick; FSM, song table and tone registers stay in music_sequencer.

Verification (TICKS_PER_BEAT=4, SONG_LEN=64, NUM_CH=2)
REQ-038 Reset, start 1 cycle -> playing=1, beat_num 0, tone=262 on both channels next cycle; beat_num=1 after 4 cycles; tone=294 at beat 4.
REQ-039 loop_en=0, run 256 cycles -> done pulses one cycle after beat 63, state IDLE, tone=50000000; loop_en=1 -> beat_num wraps 63->0, no done.
REQ-040 pause at beat 10 for 20 cycles -> beat_num stays 10, tone silence; release -> beat 11 after remaining ticks.
REQ-041 oct_up=1 at beat 0 -> tone 524; oct_dn=1 -> 131; both -> 262; beat 60 -> 50000000 in all cases; mute=2'b10 -> ch1 silent, ch0 262.
REQ-042 stop and start same cycle during PLAY -> IDLE, beat 0; rst asserted mid-song -> all outputs reset values immediately.
